// File: rtl/logic_unit_pipe_if.sv
// Handshake bus for logic_unit_pipe: operand/opcode input channel and result output channel.
// The slave modport is the pipeline's view; the master modport is the source/sink view.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic [2:0]       op_q;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, zero, parity, op_q
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, zero, parity, op_q
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control,
// zero/parity flags on the result and a wrapping completed-transaction counter.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  logic_unit_pipe_if.slave    bus,
  output logic [CNT_W-1:0]    txn_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic             s2_zero;
  logic             s2_parity;
  logic [2:0]       s2_op;

  logic [WIDTH-1:0] result;
  logic             s1_adv;
  logic             s2_adv;
  logic             out_fire;

  // A stage may take new contents when it is empty or its occupant is leaving this cycle.
  assign s2_adv   = !s2_valid || bus.out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign out_fire = s2_valid && bus.out_ready;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.y         = s2_y;
  assign bus.zero      = s2_zero;
  assign bus.parity    = s2_parity;
  assign bus.op_q      = s2_op;

  always_comb begin
    result = s1_a;
    case (s1_op)
      3'd0:    result = s1_a & s1_b;
      3'd1:    result = s1_a | s1_b;
      3'd2:    result = ~(s1_a & s1_b);
      3'd3:    result = ~(s1_a | s1_b);
      3'd4:    result = s1_a ^ s1_b;
      3'd5:    result = ~(s1_a ^ s1_b);
      3'd6:    result = ~s1_a;
      default: result = s1_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      s2_valid  <= 1'b0;
      s2_y      <= '0;
      s2_zero   <= 1'b0;
      s2_parity <= 1'b0;
      s2_op     <= '0;
      txn_cnt   <= '0;
    end else begin
      // Result registers only load on a real transaction so a stalled or drained output stays put.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_y      <= result;
          s2_zero   <= ~|result;
          s2_parity <= ^result;
          s2_op     <= s1_op;
        end
      end
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a  <= bus.a;
          s1_b  <= bus.b;
          s1_op <= bus.op;
        end
      end
      if (out_fire) begin
        txn_cnt <= txn_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed check of logic_unit_pipe against a transaction-level scoreboard;
// a second instance with a 3-bit counter runs in lockstep to exercise counter wrap.
module tb_logic_unit_pipe;

  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
    int         acc_cyc;
  } txn_t;

  logic clk;
  logic rst_n;
  logic [15:0] txn_cnt;
  logic [2:0]  txn_cnt3;

  logic_unit_pipe_if #(.WIDTH(8)) bus ();
  logic_unit_pipe_if #(.WIDTH(8)) bus3 ();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .txn_cnt(txn_cnt)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .txn_cnt(txn_cnt3)
  );

  assign bus3.in_valid  = bus.in_valid;
  assign bus3.a         = bus.a;
  assign bus3.b         = bus.b;
  assign bus3.op        = bus.op;
  assign bus3.out_ready = bus.out_ready;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   cnt   = 0;
  txn_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] refLogic(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the scoreboard, advance the model.
  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op, input logic ordy, output logic accepted);
    logic exp_rdy;
    logic exp_ov;
    logic [7:0] hy;
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !(q.size() == 2 && !ordy);
    exp_ov  = (q.size() > 0) && (cyc - q[0].acc_cyc >= 2);
    checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    checkOutput("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    checkOutput("out_valid3", 32'(bus3.out_valid), 32'(exp_ov));
    if (exp_ov && bus.out_valid) begin
      hy = q[0].y;
      checkOutput("y", 32'(bus.y), 32'(hy));
      checkOutput("zero", 32'(bus.zero), 32'(hy == 8'h00));
      checkOutput("parity", 32'(bus.parity), 32'($countones(hy) % 2));
      checkOutput("op_q", 32'(bus.op_q), 32'(q[0].op));
    end
    checkOutput("txn_cnt", 32'(txn_cnt), cnt & 32'hFFFF);
    checkOutput("txn_cnt3", 32'(txn_cnt3), cnt & 32'h7);
    if (exp_ov && ordy) begin
      void'(q.pop_front());
      cnt++;
    end
    accepted = v && exp_rdy;
    if (accepted) q.push_back('{y: refLogic(op, a, b), op: op, acc_cyc: cyc});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic doReset(input int n);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    cnt = 0;
    cyc++;
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_y", 32'(bus.y), 32'd0);
    checkOutput("rst_zero", 32'(bus.zero), 32'd0);
    checkOutput("rst_parity", 32'(bus.parity), 32'd0);
    checkOutput("rst_op_q", 32'(bus.op_q), 32'd0);
    checkOutput("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    checkOutput("rst_txn_cnt3", 32'(txn_cnt3), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, ordy, acc);
  endtask

  initial begin
    logic acc;
    int   sent;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b0;
    doReset(3);

    // Single AND: expect 0xC0 two cycles later.
    applyStimulus(1'b1, 8'hF0, 8'hCC, 3'd0, 1'b1, acc);
    idle(3, 1'b1);
    checkOutput("single_cnt", 32'(txn_cnt), 32'd1);

    // Opcode sweep back to back.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b1, acc);
    idle(3, 1'b1);
    checkOutput("sweep_cnt", 32'(txn_cnt), 32'd9);

    // Flag corner cases.
    applyStimulus(1'b1, 8'h5A, 8'h5A, 3'd4, 1'b1, acc);
    applyStimulus(1'b1, 8'h01, 8'hFF, 3'd7, 1'b1, acc);
    idle(3, 1'b1);

    // Backpressure: four ops offered, sink stalled for five cycles.
    sent = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(sent < 4, 8'(8'h10 + sent), 8'h3C, 3'(sent + 1), 1'b0, acc);
      if (acc) sent++;
    end
    checkOutput("bp_accepted", 32'(sent), 32'd2);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(sent < 4, 8'(8'h10 + sent), 8'h3C, 3'(sent + 1), 1'b1, acc);
      if (acc) sent++;
    end
    checkOutput("bp_drained", 32'(q.size()), 32'd0);

    // Reset with two transactions in flight.
    applyStimulus(1'b1, 8'hAA, 8'h0F, 3'd1, 1'b0, acc);
    applyStimulus(1'b1, 8'h55, 8'hF0, 3'd2, 1'b0, acc);
    doReset(1);
    applyStimulus(1'b1, 8'h3C, 8'h0F, 3'd5, 1'b1, acc);
    idle(3, 1'b1);
    checkOutput("post_rst_cnt", 32'(txn_cnt), 32'd1);

    // Random traffic with independent source and sink stalls.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0, acc);
    end
    idle(4, 1'b1);
    checkOutput("final_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
